// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the FIFO-drain serial transmitter.
package fifo_serial_tx_pkg;

  localparam int unsigned DEF_DATA_W       = 4;
  localparam int unsigned DEF_CLKS_PER_BIT = 4;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, parked at 0 otherwise.
// bit_tick marks the last cycle of a bit; bit_tick_next says the following
// cycle will be the last one of the current bit (used to register frame_done).
module tx_bit_timer
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_tick,
  output logic bit_tick_next
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] AHEAD = CNT_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [CNT_W-1:0] cnt_q;

  // Cycle counter within the current bit; reloads on every bit boundary.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= CNT_W'(cnt_q + 1'b1);
    end
  end

  assign bit_tick      = run && (cnt_q == LAST);
  assign bit_tick_next = run && (CLKS_PER_BIT > 1) && (cnt_q == AHEAD);

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO drain + UART-style serialiser: start bit, DATA_W bits LSB first,
// optional even parity, stop bit. Owns the FIFO read strobe.
// Optional parity bit: define FIFO_SERIAL_TX_PARITY_EN.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic                   serial_d, rd_en_d, busy_d, frame_done_d;
  logic                   run, bit_tick, bit_tick_next;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // Timer only runs while a bit is on the line.
  assign run = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .bit_tick      (bit_tick),
    .bit_tick_next (bit_tick_next)
  );

  // Next-state, datapath and next-output logic; outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_enable && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d   = fifo_data;
        bit_cnt_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        state_d   = START;
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
            shreg_d   = shreg_q >> 1;
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_d = (tx_enable && !fifo_empty) ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);

    case (state_d)
      START:   serial_d = START_LEVEL;
      DATA:    serial_d = shreg_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      STOP:    serial_d = STOP_LEVEL;
      default: serial_d = IDLE_LEVEL;
    endcase

    // Pulse lands on the last STOP cycle: either the timer is one short of its
    // end while staying in STOP, or STOP is being entered and is one cycle long.
    frame_done_d = (state_d == STOP) &&
                   ((state_q == STOP) ? bit_tick_next : (CLKS_PER_BIT == 1));
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      serial_out <= IDLE_LEVEL;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      serial_out <= serial_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model on the read side, frame scoreboard on the line.
// Build with FIFO_SERIAL_TX_PARITY_EN to exercise the parity variant.
module tb_fifo_serial_tx;

  localparam int unsigned DW  = 4;
  localparam int unsigned CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NBITS = 2 + DW + P;
  localparam int unsigned FRAME = NBITS * CPB;
  localparam logic [31:0] FRAME_MASK = 32'((64'(1) << FRAME) - 1);
  localparam int START_TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_enable;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_rd_en;
  logic          serial_out;
  logic          busy;
  logic          frame_done;

  logic          push_v;
  logic [DW-1:0] push_d;

  int n_checks = 0;
  int n_pass   = 0;

  int rd_count     = 0;
  int rd_underflow = 0;
  int rd_double    = 0;
  logic rd_prev    = 1'b0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_serial_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Synchronous FIFO model with registered read data; also polices the read strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_count <= rd_count + 1;
      if (fq.size() == 0) rd_underflow <= rd_underflow + 1;
      else                fifo_data    <= fq.pop_front();
      if (rd_prev) rd_double <= rd_double + 1;
    end
    rd_prev <= fifo_rd_en;
    if (push_v) fq.push_back(push_d);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected line level per cycle of one frame for word w.
  function automatic logic [31:0] frame_bits(input logic [DW-1:0] w);
    logic [31:0] v;
    logic        lvl;
    int          k;
    v = '0;
    k = 0;
    for (int b = 0; b < int'(NBITS); b++) begin
      if (b == 0)                         lvl = 1'b0;
      else if (b <= int'(DW))             lvl = w[b-1];
      else if (P == 1 && b == int'(DW)+1) lvl = ^w;
      else                                lvl = 1'b1;
      for (int c = 0; c < int'(CPB); c++) begin
        v[k] = lvl;
        k++;
      end
    end
    return v;
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input bit expect_tx);
    @(negedge clk);
    push_v = 1'b1;
    push_d = d;
    if (expect_tx) exp_q.push_back(d);
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits for a start bit, records one frame and scores it against the queue head.
  // drop_at lowers tx_enable at that frame cycle; abort_at asserts reset there instead.
  task automatic watch_frame(input int drop_at, input int abort_at, output int waited);
    logic [31:0]   s_vec, d_vec, b_vec;
    logic [DW-1:0] w;
    s_vec  = '0;
    d_vec  = '0;
    b_vec  = '0;
    waited = 0;
    @(negedge clk);
    while (serial_out !== 1'b0 && waited < START_TIMEOUT) begin
      waited++;
      @(negedge clk);
    end
    if (serial_out !== 1'b0) begin
      check("start_seen", 32'(serial_out), 32'd0);
      return;
    end
    for (int i = 0; i < int'(FRAME); i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_serial", 32'(serial_out), 32'd1);
        check("abort_busy",   32'(busy),       32'd0);
        check("abort_rd_en",  32'(fifo_rd_en), 32'd0);
        return;
      end
      if (i == drop_at) tx_enable = 1'b0;
      s_vec[i] = serial_out;
      d_vec[i] = frame_done;
      b_vec[i] = busy;
    end
    if (exp_q.size() == 0) begin
      check("sb_unexpected_frame", 32'(exp_q.size()), 32'd1);
      return;
    end
    w = exp_q.pop_front();
    check("frame_bits", s_vec, frame_bits(w));
    check("frame_done", d_vec, 32'(1) << (FRAME - 1));
    check("frame_busy", b_vec, FRAME_MASK);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int waited;
    int rd_base;
    reset     = 1'b1;
    tx_enable = 1'b1;
    push_v    = 1'b0;
    push_d    = '0;

    // Reset held with a word waiting and tx_enable high: nothing moves.
    push_word(4'hA, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_serial", 32'(serial_out), 32'd1);
      check("rst_rd_en",  32'(fifo_rd_en), 32'd0);
      check("rst_busy",   32'(busy),       32'd0);
    end
    check("rst_no_read", 32'(rd_count), 32'd0);

    // Single frame of 4'hA.
    rd_base = rd_count;
    reset = 1'b0;
    watch_frame(-1, -1, waited);
    check("a_latency", 32'(waited), 32'd2);
    wait_cycles(4);
    check("a_rd_pulses", 32'(rd_count - rd_base), 32'd1);
    check("a_idle_busy", 32'(busy), 32'd0);

    // Back-to-back 4'h3 then 4'h7.
    tx_enable = 1'b0;
    push_word(4'h3, 1'b1);
    push_word(4'h7, 1'b1);
    rd_base = rd_count;
    tx_enable = 1'b1;
    watch_frame(-1, -1, waited);
    check("b2b_first_latency", 32'(waited), 32'd2);
    watch_frame(-1, -1, waited);
    check("b2b_gap", 32'(waited), 32'd2);
    wait_cycles(4);
    check("b2b_rd_pulses", 32'(rd_count - rd_base), 32'd2);
    check("b2b_fifo_empty", 32'(fifo_empty), 32'd1);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_serial", 32'(serial_out), 32'd1);

    // tx_enable dropped in DATA of 4'h5; 4'h9 must stay in the FIFO.
    tx_enable = 1'b0;
    push_word(4'h5, 1'b1);
    push_word(4'h9, 1'b0);
    rd_base = rd_count;
    tx_enable = 1'b1;
    watch_frame(int'(2 * CPB), -1, waited);
    wait_cycles(20);
    check("drop_rd_pulses", 32'(rd_count - rd_base), 32'd1);
    check("drop_fifo_kept", 32'(fifo_empty), 32'd0);
    check("drop_idle_busy", 32'(busy), 32'd0);

    // Reset during data bit 2 of 4'h9, then a fresh frame through FETCH.
    rd_base = rd_count;
    tx_enable = 1'b1;
    watch_frame(-1, int'(3 * CPB + 1), waited);
    push_word(4'hC, 1'b1);
    check("rst_hold_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    watch_frame(-1, -1, waited);
    check("post_rst_latency", 32'(waited), 32'd2);
    wait_cycles(4);
    check("post_rst_rd_pulses", 32'(rd_count - rd_base), 32'd2);

    check("no_underflow_read", 32'(rd_underflow), 32'd0);
    check("no_double_read",    32'(rd_double),    32'd0);
    check("sb_drained",        32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
